// File: rtl/sdram_pkg.sv
// Shared command encodings, error codes, mode-register field positions and
// init-state type for the SDRAM device-side responder.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_PRE_INIT    = 3'd1;
  localparam logic [2:0] ERR_FEW_REF     = 3'd2;
  localparam logic [2:0] ERR_BANK_STATE  = 3'd3;
  localparam logic [2:0] ERR_BAD_MODE    = 3'd4;
  localparam logic [2:0] ERR_CLOSED_BANK = 3'd5;
  localparam logic [2:0] ERR_CONTENTION  = 3'd6;

  localparam int MODE_BL_LSB  = 0;
  localparam int MODE_BT_BIT  = 3;
  localparam int MODE_CL_LSB  = 4;
  localparam int MODE_WB_BIT  = 9;
  localparam int AUTO_PRE_BIT = 10;

  typedef enum logic [1:0] {
    S_WAIT_PRE,
    S_WAIT_REF,
    S_READY
  } init_state_t;

  // Only burst length 1 with CAS latency 2 or 3 is modelled.
  function automatic logic mode_supported(input logic [12:0] a);
    return (a[MODE_BL_LSB +: 3] == 3'b000) &&
           ((a[MODE_CL_LSB +: 3] == 3'b010) || (a[MODE_CL_LSB +: 3] == 3'b011));
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Byte-maskable single-port storage array with synchronous write and a
// registered read port; the array itself is never reset.
module sdram_resp_mem #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 we,
  input  logic [1:0]           be,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge iclk) begin
    if (we) begin
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_cmd_responder.sv
// SDR SDRAM device stand-in: decodes pin commands, enforces the power-up
// init sequence, tracks open rows and serves single-beat reads and writes.
module sdram_cmd_responder
  import sdram_pkg::*;
#(
  parameter int INIT_REFRESHES = 2,
  parameter int MEM_ROW_BITS   = 4,
  parameter int MEM_COL_BITS   = 6
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        dram_cke,
  input  logic        dram_cs_n,
  input  logic        dram_ras_n,
  input  logic        dram_cas_n,
  input  logic        dram_we_n,
  input  logic [1:0]  dram_ba,
  input  logic [12:0] dram_addr,
  input  logic        dram_ldqm,
  input  logic        dram_udqm,
  input  logic [15:0] dram_dq_in,
  output logic [15:0] dram_dq_out,
  output logic [1:0]  dram_dq_oe,
  output logic        oinit_done,
  output logic [1:0]  ocas_latency,
  output logic [3:0]  obank_open,
  output logic        oerr,
  output logic [2:0]  oerr_code
);

  localparam int MEM_ADDR_BITS = 2 + MEM_ROW_BITS + MEM_COL_BITS;
  localparam logic [3:0] INIT_REF_MIN = 4'(INIT_REFRESHES);

  init_state_t state, state_n;
  logic [3:0]  ref_cnt, ref_cnt_n;
  logic [3:0]  bank_open, bank_open_n;
  logic [MEM_ROW_BITS-1:0] open_row [4];
  logic [1:0]  cas_lat;
  logic        mode_bt, mode_wb;

  logic [3:0]  cmd;
  logic        no_op, auto_pre, mode_load, act_load, mem_we, mem_re;
  logic        e_pre_init, e_few_ref, e_bank, e_mode, e_closed, e_cont;
  logic [2:0]  err_code_n;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [15:0] mem_rdata;

  logic        p1_valid, p2_valid;
  logic [1:0]  p1_mask, p2_mask;
  logic [15:0] p2_data;
  logic        src_valid;
  logic [1:0]  src_mask;
  logic [15:0] src_data;
  logic        unused_ok;

  // A suspended clock looks exactly like a NOP to the decoder.
  assign cmd      = (dram_cke && !dram_cs_n) ? {1'b0, dram_ras_n, dram_cas_n, dram_we_n} : CMD_NOP;
  assign no_op    = (cmd == CMD_NOP) || (cmd == CMD_BST);
  assign auto_pre = dram_addr[AUTO_PRE_BIT];
  assign mem_addr = {dram_ba, open_row[dram_ba], dram_addr[MEM_COL_BITS-1:0]};

  always_comb begin
    state_n     = state;
    ref_cnt_n   = ref_cnt;
    bank_open_n = bank_open;
    mode_load   = 1'b0;
    act_load    = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    e_pre_init  = 1'b0;
    e_few_ref   = 1'b0;
    e_bank      = 1'b0;
    e_mode      = 1'b0;
    e_closed    = 1'b0;
    e_cont      = (cmd == CMD_WR) && (dram_dq_oe != 2'b00);
    case (state)
      S_WAIT_PRE: begin
        if (cmd == CMD_PRE && auto_pre) state_n = S_WAIT_REF;
        else if (!no_op)                e_pre_init = 1'b1;
      end
      S_WAIT_REF: begin
        case (cmd)
          CMD_REF: if (ref_cnt != 4'hF) ref_cnt_n = ref_cnt + 4'd1;
          CMD_MRS: begin
            if (ref_cnt < INIT_REF_MIN)          e_few_ref = 1'b1;
            else if (!mode_supported(dram_addr)) e_mode = 1'b1;
            else begin
              mode_load = 1'b1;
              state_n   = S_READY;
            end
          end
          CMD_ACT, CMD_RD, CMD_WR: e_pre_init = 1'b1;
          default: ;
        endcase
      end
      default: begin
        case (cmd)
          CMD_MRS: begin
            if (bank_open != 4'b0)               e_bank = 1'b1;
            else if (!mode_supported(dram_addr)) e_mode = 1'b1;
            else                                 mode_load = 1'b1;
          end
          CMD_ACT: begin
            if (bank_open[dram_ba]) e_bank = 1'b1;
            else begin
              bank_open_n[dram_ba] = 1'b1;
              act_load             = 1'b1;
            end
          end
          CMD_PRE: begin
            if (auto_pre) bank_open_n = 4'b0;
            else          bank_open_n[dram_ba] = 1'b0;
          end
          CMD_REF: if (bank_open != 4'b0) e_bank = 1'b1;
          CMD_RD, CMD_WR: begin
            if (!bank_open[dram_ba]) e_closed = 1'b1;
            else begin
              mem_re = (cmd == CMD_RD);
              mem_we = (cmd == CMD_WR);
              if (auto_pre) bank_open_n[dram_ba] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    endcase
    if (e_pre_init)    err_code_n = ERR_PRE_INIT;
    else if (e_few_ref) err_code_n = ERR_FEW_REF;
    else if (e_bank)   err_code_n = ERR_BANK_STATE;
    else if (e_mode)   err_code_n = ERR_MODE_SEL();
    else if (e_closed) err_code_n = ERR_CLOSED_BANK;
    else if (e_cont)   err_code_n = ERR_CONTENTION;
    else               err_code_n = ERR_NONE;
  end

  function automatic logic [2:0] ERR_MODE_SEL();
    return ERR_BAD_MODE;
  endfunction

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) state <= S_WAIT_PRE;
    else        state <= state_n;
  end

  // CL2 serves straight from the array's read register, CL3 one stage later.
  always_comb begin
    src_valid = p2_valid;
    src_mask  = p2_mask;
    src_data  = p2_data;
    if (cas_lat == 2'd2) begin
      src_valid = p1_valid;
      src_mask  = p1_mask;
      src_data  = mem_rdata;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      ref_cnt     <= '0;
      bank_open   <= '0;
      cas_lat     <= 2'd2;
      mode_bt     <= 1'b0;
      mode_wb     <= 1'b0;
      for (int i = 0; i < 4; i++) open_row[i] <= '0;
      oerr        <= 1'b0;
      oerr_code   <= ERR_NONE;
      p1_valid    <= 1'b0;
      p1_mask     <= '0;
      p2_valid    <= 1'b0;
      p2_mask     <= '0;
      p2_data     <= '0;
      dram_dq_out <= '0;
      dram_dq_oe  <= '0;
    end else begin
      ref_cnt   <= ref_cnt_n;
      bank_open <= bank_open_n;
      oerr      <= (err_code_n != ERR_NONE);
      if (err_code_n != ERR_NONE) oerr_code <= err_code_n;
      if (mode_load) begin
        cas_lat <= dram_addr[MODE_CL_LSB +: 2];
        mode_bt <= dram_addr[MODE_BT_BIT];
        mode_wb <= dram_addr[MODE_WB_BIT];
      end
      if (act_load) open_row[dram_ba] <= dram_addr[MEM_ROW_BITS-1:0];
      if (dram_cke) begin
        p1_valid   <= mem_re;
        p1_mask    <= {~dram_udqm, ~dram_ldqm};
        p2_valid   <= p1_valid;
        p2_mask    <= p1_mask;
        p2_data    <= mem_rdata;
        dram_dq_oe <= src_valid ? src_mask : 2'b00;
        if (src_valid) dram_dq_out <= src_data;
      end
    end
  end

  sdram_resp_mem #(
    .ADDR_BITS(MEM_ADDR_BITS)
  ) u_mem (
    .iclk  (iclk),
    .ireset(ireset),
    .we    (mem_we),
    .be    ({~dram_udqm, ~dram_ldqm}),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (dram_dq_in),
    .rdata (mem_rdata)
  );

  assign oinit_done   = (state == S_READY);
  assign ocas_latency = cas_lat;
  assign obank_open   = bank_open;
  assign unused_ok    = ^{mode_bt, mode_wb, dram_addr};

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed-vector bench for sdram_cmd_responder: init sequence, error codes,
// CL2/CL3 read timing, byte masking and reset during an in-flight read.
module tb_sdram_cmd_responder;
  import sdram_pkg::*;

  logic        iclk = 1'b0;
  logic        ireset;
  logic        dram_cke;
  logic        dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
  logic [1:0]  dram_ba;
  logic [12:0] dram_addr;
  logic        dram_ldqm, dram_udqm;
  logic [15:0] dram_dq_in;
  logic [15:0] dram_dq_out;
  logic [1:0]  dram_dq_oe;
  logic        oinit_done;
  logic [1:0]  ocas_latency;
  logic [3:0]  obank_open;
  logic        oerr;
  logic [2:0]  oerr_code;

  int vectors     = 0;
  int miscompares = 0;

  sdram_cmd_responder dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .dram_cke    (dram_cke),
    .dram_cs_n   (dram_cs_n),
    .dram_ras_n  (dram_ras_n),
    .dram_cas_n  (dram_cas_n),
    .dram_we_n   (dram_we_n),
    .dram_ba     (dram_ba),
    .dram_addr   (dram_addr),
    .dram_ldqm   (dram_ldqm),
    .dram_udqm   (dram_udqm),
    .dram_dq_in  (dram_dq_in),
    .dram_dq_out (dram_dq_out),
    .dram_dq_oe  (dram_dq_oe),
    .oinit_done  (oinit_done),
    .ocas_latency(ocas_latency),
    .obank_open  (obank_open),
    .oerr        (oerr),
    .oerr_code   (oerr_code)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic setNop();
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = CMD_NOP;
    dram_ba    = 2'd0;
    dram_addr  = 13'd0;
    dram_ldqm  = 1'b0;
    dram_udqm  = 1'b0;
    dram_dq_in = 16'd0;
  endtask

  // Drives one command for exactly one rising edge, then returns to NOP.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [1:0] ba,
                               input logic [12:0] addr, input logic udqm,
                               input logic ldqm, input logic [15:0] dq);
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd;
    dram_ba    = ba;
    dram_addr  = addr;
    dram_udqm  = udqm;
    dram_ldqm  = ldqm;
    dram_dq_in = dq;
    tick();
    setNop();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doInit(input logic [12:0] mrs);
    applyStimulus(CMD_PRE, 2'd0, 13'h400, 1'b0, 1'b0, 16'h0);
    applyStimulus(CMD_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
    applyStimulus(CMD_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
    applyStimulus(CMD_MRS, 2'd0, mrs, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    ireset   = 1'b1;
    dram_cke = 1'b1;
    setNop();
    tick();
    tick();
    ireset = 1'b0;
    tick();
    checkOutput("rst_dq_out", dram_dq_out, 16'h0000);
    checkOutput("rst_dq_oe", {14'd0, dram_dq_oe}, 16'h0000);
    checkOutput("rst_init_done", {15'd0, oinit_done}, 16'h0000);
    checkOutput("rst_cas_latency", {14'd0, ocas_latency}, 16'h0002);
    checkOutput("rst_bank_open", {12'd0, obank_open}, 16'h0000);
    checkOutput("rst_err", {15'd0, oerr}, 16'h0000);
    checkOutput("rst_err_code", {13'd0, oerr_code}, 16'h0000);

    $display("[TB] command before init and too-few refreshes");
    applyStimulus(CMD_WR, 2'd0, 13'h000, 1'b0, 1'b0, 16'hDEAD);
    checkOutput("wr_pre_init_err", {15'd0, oerr}, 16'h0001);
    checkOutput("wr_pre_init_code", {13'd0, oerr_code}, 16'h0001);
    applyStimulus(CMD_PRE, 2'd0, 13'h400, 1'b0, 1'b0, 16'h0);
    checkOutput("pre_all_no_err", {15'd0, oerr}, 16'h0000);
    checkOutput("code_held", {13'd0, oerr_code}, 16'h0001);
    applyStimulus(CMD_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
    checkOutput("ref1_no_err", {15'd0, oerr}, 16'h0000);
    applyStimulus(CMD_MRS, 2'd0, 13'h220, 1'b0, 1'b0, 16'h0);
    checkOutput("mrs_few_ref_err", {15'd0, oerr}, 16'h0001);
    checkOutput("mrs_few_ref_code", {13'd0, oerr_code}, 16'h0002);
    checkOutput("mrs_few_ref_not_done", {15'd0, oinit_done}, 16'h0000);
    applyStimulus(CMD_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
    checkOutput("ref2_no_err", {15'd0, oerr}, 16'h0000);
    applyStimulus(CMD_MRS, 2'd0, 13'h220, 1'b0, 1'b0, 16'h0);
    checkOutput("mrs_ok_no_err", {15'd0, oerr}, 16'h0000);
    checkOutput("init_done", {15'd0, oinit_done}, 16'h0001);
    checkOutput("cl2", {14'd0, ocas_latency}, 16'h0002);

    $display("[TB] CL2 masked write/read and bus contention");
    applyStimulus(CMD_ACT, 2'd1, 13'h005, 1'b0, 1'b0, 16'h0);
    checkOutput("act_b1_open", {12'd0, obank_open}, 16'h0002);
    applyStimulus(CMD_WR, 2'd1, 13'h003, 1'b1, 1'b0, 16'hBEEF);
    checkOutput("wr_lo_no_err", {15'd0, oerr}, 16'h0000);
    applyStimulus(CMD_RD, 2'd1, 13'h003, 1'b1, 1'b0, 16'h0);
    checkOutput("cl2_oe_edge_n", {14'd0, dram_dq_oe}, 16'h0000);
    tick();
    checkOutput("cl2_oe_edge_n1", {14'd0, dram_dq_oe}, 16'h0001);
    checkOutput("cl2_lo_byte", {8'd0, dram_dq_out[7:0]}, 16'h00EF);
    applyStimulus(CMD_WR, 2'd1, 13'h004, 1'b0, 1'b0, 16'h1234);
    checkOutput("contention_err", {15'd0, oerr}, 16'h0001);
    checkOutput("contention_code", {13'd0, oerr_code}, 16'h0006);
    checkOutput("oe_one_cycle", {14'd0, dram_dq_oe}, 16'h0000);

    $display("[TB] bank-state conflicts");
    applyStimulus(CMD_ACT, 2'd1, 13'h009, 1'b0, 1'b0, 16'h0);
    checkOutput("act_open_code", {13'd0, oerr_code}, 16'h0003);
    checkOutput("act_open_banks", {12'd0, obank_open}, 16'h0002);
    applyStimulus(CMD_RD, 2'd2, 13'h000, 1'b0, 1'b0, 16'h0);
    checkOutput("rd_closed_err", {15'd0, oerr}, 16'h0001);
    checkOutput("rd_closed_code", {13'd0, oerr_code}, 16'h0005);
    tick();
    checkOutput("rd_closed_no_oe", {14'd0, dram_dq_oe}, 16'h0000);
    tick();
    checkOutput("rd_closed_no_oe2", {14'd0, dram_dq_oe}, 16'h0000);
    applyStimulus(CMD_PRE, 2'd0, 13'h400, 1'b0, 1'b0, 16'h0);
    checkOutput("pre_all_banks", {12'd0, obank_open}, 16'h0000);
    applyStimulus(CMD_MRS, 2'd0, 13'h030, 1'b0, 1'b0, 16'h0);
    checkOutput("mrs_cl3_no_err", {15'd0, oerr}, 16'h0000);
    checkOutput("cl3", {14'd0, ocas_latency}, 16'h0003);

    $display("[TB] CL3 back-to-back reads");
    applyStimulus(CMD_ACT, 2'd1, 13'h005, 1'b0, 1'b0, 16'h0);
    applyStimulus(CMD_WR, 2'd1, 13'h000, 1'b0, 1'b0, 16'h1111);
    applyStimulus(CMD_WR, 2'd1, 13'h001, 1'b0, 1'b0, 16'h2222);
    applyStimulus(CMD_WR, 2'd1, 13'h002, 1'b0, 1'b0, 16'h3333);
    applyStimulus(CMD_RD, 2'd1, 13'h000, 1'b0, 1'b0, 16'h0);
    checkOutput("cl3_oe_n", {14'd0, dram_dq_oe}, 16'h0000);
    applyStimulus(CMD_RD, 2'd1, 13'h001, 1'b0, 1'b0, 16'h0);
    checkOutput("cl3_oe_n1", {14'd0, dram_dq_oe}, 16'h0000);
    applyStimulus(CMD_RD, 2'd1, 13'h002, 1'b0, 1'b0, 16'h0);
    checkOutput("cl3_beat0_oe", {14'd0, dram_dq_oe}, 16'h0003);
    checkOutput("cl3_beat0", dram_dq_out, 16'h1111);
    tick();
    checkOutput("cl3_beat1_oe", {14'd0, dram_dq_oe}, 16'h0003);
    checkOutput("cl3_beat1", dram_dq_out, 16'h2222);
    tick();
    checkOutput("cl3_beat2_oe", {14'd0, dram_dq_oe}, 16'h0003);
    checkOutput("cl3_beat2", dram_dq_out, 16'h3333);
    tick();
    checkOutput("cl3_burst_end_oe", {14'd0, dram_dq_oe}, 16'h0000);

    $display("[TB] reset during in-flight reads");
    applyStimulus(CMD_RD, 2'd1, 13'h004, 1'b0, 1'b0, 16'h0);
    applyStimulus(CMD_RD, 2'd1, 13'h001, 1'b0, 1'b0, 16'h0);
    tick();
    checkOutput("contention_wr_data", dram_dq_out, 16'h1234);
    checkOutput("pre_reset_oe", {14'd0, dram_dq_oe}, 16'h0003);
    #2;
    ireset = 1'b1;
    #1;
    checkOutput("async_reset_oe", {14'd0, dram_dq_oe}, 16'h0000);
    checkOutput("async_reset_init", {15'd0, oinit_done}, 16'h0000);
    checkOutput("async_reset_banks", {12'd0, obank_open}, 16'h0000);
    checkOutput("async_reset_cl", {14'd0, ocas_latency}, 16'h0002);
    tick();
    ireset = 1'b0;
    tick();
    tick();
    checkOutput("flushed_pipeline_oe", {14'd0, dram_dq_oe}, 16'h0000);
    applyStimulus(CMD_WR, 2'd1, 13'h001, 1'b0, 1'b0, 16'hAAAA);
    checkOutput("reset_fsm_code", {13'd0, oerr_code}, 16'h0001);
    doInit(13'h220);
    checkOutput("reinit_done", {15'd0, oinit_done}, 16'h0001);
    applyStimulus(CMD_ACT, 2'd1, 13'h005, 1'b0, 1'b0, 16'h0);
    applyStimulus(CMD_RD, 2'd1, 13'h401, 1'b0, 1'b0, 16'h0);
    checkOutput("rd_autopre_banks", {12'd0, obank_open}, 16'h0000);
    tick();
    checkOutput("survive_reset_oe", {14'd0, dram_dq_oe}, 16'h0003);
    checkOutput("survive_reset_data", dram_dq_out, 16'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_responder.md
Name: sdram_cmd_responder

Overview:
- Device-side responder for the 16-bit SDR SDRAM pin interface: decodes CS/RAS/CAS/WE commands from a controller, enforces the power-up init sequence, latches the mode register, tracks per-bank open rows, and services single-beat READ/WRITE from a small modelled array.
- Used as the SDRAM stand-in for controller bring-up and on-chip loopback self-test, with error reporting.

Parameters:
- INIT_REFRESHES, 2: minimum AUTO REFRESH commands required between PRECHARGE ALL and LOAD MODE.
- MEM_ROW_BITS, 4: row LSBs modelled per bank; upper row bits are ignored (aliasing).
- MEM_COL_BITS, 6: column LSBs modelled; upper column bits are ignored.

Ports:
- iclk  in  1  clock
- ireset  in  1  reset
- dram_cke  in  1  clock enable; low = clock suspend
- dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  in  1 each  command
- dram_ba  in  2  bank address
- dram_addr  in  13  row, column or mode-register bits; A10 = auto/all-bank precharge
- dram_ldqm, dram_udqm  in  1 each  byte masks
- dram_dq_in  in  16  write data
- dram_dq_out  out  16  read data
- dram_dq_oe  out  2  per-byte drive enable, {upper, lower}
- oinit_done  out  1  init sequence complete
- ocas_latency  out  2  latched CAS latency (2 or 3)
- obank_open  out  4  per-bank row-open flags
- oerr  out  1  one-cycle protocol-error pulse
- oerr_code  out  3  code of the last error, held until the next error

Behaviour:
- Reset is ireset, asynchronous, active-high; clock is iclk.
- Reset values:
  - dram_dq_out=0, dram_dq_oe=0
  - oinit_done=0, ocas_latency=2, obank_open=0
  - oerr=0, oerr_code=0
  - init FSM=S_WAIT_PRE, refresh count=0, read pipeline cleared
  - memory array not reset; contents survive a mid-operation reset
- Command decode {cs,ras,cas,we}:
  - 1xxx deselect and 0111 NOP: no action.
  - 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO REFRESH, 0000 LOAD MODE, 0110 BURST TERMINATE (treated as NOP).
  - Commands are sampled on rising iclk only when dram_cke=1.
  - dram_cke=0: command ignored, read pipeline frozen, outputs held.
- Init FSM:
  - S_WAIT_PRE: PRECHARGE with A10=1 -> S_WAIT_REF. Any other non-NOP -> err 1; state unchanged.
  - S_WAIT_REF: each AUTO REFRESH increments the count (saturating at 15). LOAD MODE with count>=INIT_REFRESHES -> S_READY. LOAD MODE with too few refreshes -> err 2; stay. READ/WRITE/ACTIVE -> err 1.
  - S_READY: oinit_done=1 from the edge after the accepted LOAD MODE.
  - A later LOAD MODE is accepted in S_READY only if obank_open=0; otherwise err 3.
- LOAD MODE field check:
  - A[2:0] must be 000 (burst length 1).
  - A[6:4] must be 010 or 011 (CL 2 or 3); ocas_latency updates.
  - A9 and A3 are stored and otherwise ignored.
  - Unsupported BL or CL -> err 4; mode register unchanged; FSM does not advance.
- ACTIVE (READY only):
  - Bank already open -> err 3; row not replaced.
  - Otherwise latch row, set obank_open[ba].
- PRECHARGE: A10=1 clears all banks; A10=0 clears bank ba. Precharging an idle bank is legal.
- AUTO REFRESH in READY with any bank open -> err 3.
- READ/WRITE to a closed bank -> err 5; no array access, no data driven.
- Array index: {ba, open_row[MEM_ROW_BITS-1:0], addr[MEM_COL_BITS-1:0]}.
- A10=1 on READ/WRITE: bank auto-precharges on the same edge, after the access.
- WRITE: dram_dq_in is captured on the command edge. Lower byte is written if ldqm=0; upper byte if udqm=0.
- READ, command on edge N:
  - Data from a 3-deep shift pipeline is registered on edge N+CL-1, for controller sampling at edge N+CL.
  - dram_dq_oe = {~udqm, ~ldqm} as sampled at edge N, held for exactly one cycle.
  - Back-to-back READs every cycle yield consecutive data beats.
- WRITE sampled on an edge where dram_dq_oe!=0 is being driven: err 6 (bus contention). The write is still performed.
- Multiple errors on one edge: lowest code wins; oerr pulses once.
- oerr_code values: 1 cmd-before-init, 2 too-few-refresh, 3 bank-state conflict, 4 bad mode, 5 access-to-closed-bank, 6 contention.

Decomposition:
- Package sdram_pkg:
  - 4-bit command encodings CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_BST
  - error code constants
  - mode field bit positions
  - init FSM state typedef
- One sub-module, sdram_resp_mem: byte-maskable, single-port, synchronous-write, registered-read array sized 4*2^(ROW+COL) x 16.

Test Plan:
- Init: PRE with A10=1, 2x REF, MRS addr=0x220 -> oinit_done=1 on the next edge, ocas_latency=2, oerr never pulses.
- WRITE before init: oerr=1 with code 1. MRS after 1 REF (INIT_REFRESHES=2): code 2, oinit_done stays 0.
- After init (CL=2): ACT bank 1 row 5; WR col 3 data 0xBEEF with udqm=1 -> lower byte only; RD col 3 -> dq_out=0x??EF, dq_oe=01 at edge N+2.
- After MRS with CL=3: back-to-back RD cols 0,1,2 -> three consecutive beats starting at edge N+3, dq_oe=11 for 3 cycles.
- ACT on an open bank -> code 3. RD to an idle bank -> code 5, dq_oe stays 0. PRE with A10=1 -> obank_open=0000.
- ireset asserted between a RD command and its data -> dq_oe=0 immediately, FSM back to S_WAIT_PRE; after re-init, earlier written data reads back intact.
